dac_i2c_master: RTL and testbench

Byte-level I2C write engine that sits directly downstream of the dac_i2c AXI4-Lite register file. It takes one DAC write command per handshake: 7-bit device address, 8-bit command/pointer byte and 16-bit data word. For each command it produces a complete I2C write transaction on open-drain SCL/SDA: START, address+W, command byte, data MSB, data LSB, STOP. It reports busy, a done pulse and an ACK failure flag back to the register file for status readback.

---
 rtl/dac_i2c_master.sv | 188 ++++++++++++++++++
 tb/tb_dac_i2c_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_i2c_master.sv
// rtl/dac_i2c_master.sv - byte-level I2C write engine for DAC commands
//
// Accepts one command per handshake and sends it as a single I2C write:
// START, {addr,W}, command byte, data MSB, data LSB, STOP.
// A NACK in any ACK slot ends the transfer early with a STOP.
//
// Parameter:
//   CLK_DIV    system clocks per quarter SCL bit (>= 2); SCL period = 4*CLK_DIV
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-high
//   cmd_valid  command present
//   cmd_ready  engine idle (or finishing) and able to take a command
//   cmd_addr   7-bit device address
//   cmd_byte   command/pointer byte
//   cmd_data   16-bit data word, MSB first
//   busy       transaction in progress
//   done       one-cycle pulse in the final cycle of STOP
//   nack       last transaction saw a NACK (cleared on next acceptance)
//   scl_oe     1 = pull SCL low, 0 = release
//   sda_oe     1 = pull SDA low, 0 = release
//   sda_in     synchronized SDA pad value

module dac_i2c_master #(
  parameter int CLK_DIV = 125
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_addr,
  input  logic [7:0]  cmd_byte,
  input  logic [15:0] cmd_data,
  output logic        busy,
  output logic        done,
  output logic        nack,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_in
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BYTE,
    S_ACK,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        qtr_q, qtr_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        byte_q, byte_d;
  logic [31:0]       shift_q, shift_d;
  logic              nack_q, nack_d;

  logic              tick;
  logic              phase_end;
  logic              accept;

  assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
  assign phase_end = tick && (qtr_q == 2'd3);
  assign accept    = cmd_valid && cmd_ready;
  assign nack      = nack_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      nack_q  <= nack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    nack_d    = nack_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    scl_oe    = 1'b0;
    sda_oe    = 1'b0;

    // Divider and quarter counter free-run whenever a transaction is active;
    // the quarter counter wraps naturally from q3 to q0 at each phase end.
    if (state_q != S_IDLE) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        qtr_d = qtr_q + 2'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
      end

      S_START: begin
        // SDA falls at q2 while SCL is still high, then SCL follows at q3.
        sda_oe = qtr_q[1];
        scl_oe = (qtr_q == 2'd3);
        if (phase_end) begin
          state_d = S_BYTE;
          bit_d   = '0;
        end
      end

      S_BYTE: begin
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sda_oe = ~shift_q[31];
        if (phase_end) begin
          shift_d = {shift_q[30:0], 1'b0};
          // 3-bit counter wraps to 0 after bit 7, ready for the next byte.
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_ACK;
          end
        end
      end

      S_ACK: begin
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sda_oe = 1'b0;
        // Sample in the middle of the SCL-high window (end of q1).
        if (tick && (qtr_q == 2'd1)) begin
          nack_d = sda_in;
        end
        if (phase_end) begin
          if (nack_q || (byte_q == 2'd3)) begin
            state_d = S_STOP;
          end else begin
            state_d = S_BYTE;
            byte_d  = byte_q + 2'd1;
          end
        end
      end

      S_STOP: begin
        // SDA rises at q2 while SCL is high.
        scl_oe = (qtr_q == 2'd0);
        sda_oe = ~qtr_q[1];
        if (phase_end) begin
          done      = 1'b1;
          cmd_ready = 1'b1;
          state_d   = S_IDLE;
          byte_d    = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Acceptance may happen from IDLE or in the done cycle of STOP, so it
    // overrides whatever the state logic above chose.
    if (accept) begin
      state_d = S_START;
      shift_d = {cmd_addr, 1'b0, cmd_byte, cmd_data};
      nack_d  = 1'b0;
      div_d   = '0;
      qtr_d   = '0;
      bit_d   = '0;
      byte_d  = '0;
    end
  end

  assign busy = (state_q != S_IDLE) && !done;

endmodule

// File: tb/tb_dac_i2c_master.sv
// tb/tb_dac_i2c_master.sv - scoreboard bench for dac_i2c_master at CLK_DIV 4, 2 and 125
module tb_dac_i2c_master;

  localparam int NI   = 3;
  localparam int DIV0 = 4;
  localparam int DIV1 = 2;
  localparam int DIV2 = 125;
  localparam int LIM  = 25000;

  localparam int EV_START = 32'h1000;
  localparam int EV_BYTE  = 32'h2000;
  localparam int EV_STOP  = 32'h3000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  cmd_valid = '0;
  logic [6:0]  cmd_addr = '0;
  logic [7:0]  cmd_byte = '0;
  logic [15:0] cmd_data = '0;
  logic [2:0]  cmd_ready, busy, done, nack, scl_oe, sda_oe, sda_in;
  logic [2:0]  pull = '0;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];
  int nack_at[3] = '{4, 4, 4};

  always #5 clock = ~clock;

  // Open-drain bus: a line is high only when nobody pulls it low.
  assign sda_in = ~sda_oe & ~pull;

  dac_i2c_master #(.CLK_DIV(DIV0)) u_dut0 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_addr(cmd_addr), .cmd_byte(cmd_byte), .cmd_data(cmd_data), .busy(busy[0]),
    .done(done[0]), .nack(nack[0]), .scl_oe(scl_oe[0]), .sda_oe(sda_oe[0]), .sda_in(sda_in[0])
  );
  dac_i2c_master #(.CLK_DIV(DIV1)) u_dut1 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_addr(cmd_addr), .cmd_byte(cmd_byte), .cmd_data(cmd_data), .busy(busy[1]),
    .done(done[1]), .nack(nack[1]), .scl_oe(scl_oe[1]), .sda_oe(sda_oe[1]), .sda_in(sda_in[1])
  );
  dac_i2c_master #(.CLK_DIV(DIV2)) u_dut2 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
    .cmd_addr(cmd_addr), .cmd_byte(cmd_byte), .cmd_data(cmd_data), .busy(busy[2]),
    .done(done[2]), .nack(nack[2]), .scl_oe(scl_oe[2]), .sda_oe(sda_oe[2]), .sda_in(sda_in[2])
  );

  function automatic int div_of(input int i);
    return (i == 0) ? DIV0 : ((i == 1) ? DIV1 : DIV2);
  endfunction

  // Expected bus events for one command; k is the byte the slave NACKs (4 = none).
  task automatic push_expected(input logic [6:0] a, input logic [7:0] b,
                               input logic [15:0] d, input int k);
    logic [31:0] w;
    w = {a, 1'b0, b, d};
    exp_q.push_back(EV_START);
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back(EV_BYTE + ((j == k) ? 256 : 0) + int'(w[31 - 8*j -: 8]));
      if (j == k) break;
    end
    exp_q.push_back(EV_STOP);
  endtask

  // Bus monitor + slave model + protocol checks, one pass per instance each negedge.
  initial begin : monitor
    logic [2:0] scl_p, sda_p, lat, in_frame, cond_seen;
    logic [7:0] shreg [3];
    int         bitn [3];
    int         byten [3];
    int         hi_start [3];
    int         cyc;
    scl_p = '1; sda_p = '1; lat = '0; in_frame = '0; cond_seen = '1;
    cyc = 0;
    for (int i = 0; i < NI; i++) begin
      shreg[i] = '0; bitn[i] = 0; byten[i] = 0; hi_start[i] = 0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < NI; i++) begin
        logic s, d, have_ev;
        int   ev, e;
        s = ~scl_oe[i];
        d = sda_in[i];
        have_ev = 1'b0;
        ev = 0;
        if (reset) begin
          in_frame[i] = 1'b0; bitn[i] = 0; pull[i] = 1'b0; cond_seen[i] = 1'b1;
        end else begin
          if (s && scl_p[i] && (d != sda_p[i])) begin
            cond_seen[i] = 1'b1;
            n_cmp++;
            if (!d) begin
              assert (!in_frame[i]) else begin
                n_fail++;
                $display("FAIL protocol[%0d]: SDA fell with SCL high inside frame at bit %0d, required no change", i, bitn[i]);
              end
              in_frame[i] = 1'b1; bitn[i] = -1; byten[i] = 0;
              have_ev = 1'b1; ev = EV_START;
            end else begin
              assert (in_frame[i] && bitn[i] == 0) else begin
                n_fail++;
                $display("FAIL protocol[%0d]: SDA rose with SCL high at bit %0d frame=%b, required only after ACK", i, bitn[i], in_frame[i]);
              end
              in_frame[i] = 1'b0; pull[i] = 1'b0;
              have_ev = 1'b1; ev = EV_STOP;
            end
          end
          if (s && !scl_p[i]) begin
            lat[i] = d; hi_start[i] = cyc; cond_seen[i] = 1'b0;
          end
          if (!s && scl_p[i]) begin
            if (!cond_seen[i]) begin
              n_cmp++;
              if (cyc - hi_start[i] != 2 * div_of(i)) begin
                n_fail++;
                $display("FAIL scl_high[%0d]: %0d cycles, required %0d", i, cyc - hi_start[i], 2 * div_of(i));
              end
            end
            if (in_frame[i]) begin
              bitn[i]++;
              if (bitn[i] >= 1 && bitn[i] <= 8) shreg[i] = {shreg[i][6:0], lat[i]};
              if (bitn[i] == 8) pull[i] = (byten[i] != nack_at[i]);
              if (bitn[i] == 9) begin
                have_ev = 1'b1;
                ev = EV_BYTE + (lat[i] ? 256 : 0) + int'(shreg[i]);
                byten[i]++; bitn[i] = 0; pull[i] = 1'b0;
              end
            end
          end
        end
        if (have_ev) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL bus_event[%0d]: got %0h, required none", i, ev);
          end else begin
            e = exp_q.pop_front();
            if (ev !== e) begin
              n_fail++;
              $display("FAIL bus_event[%0d]: got %0h, required %0h", i, ev, e);
            end
          end
        end
        scl_p[i] = s;
        sda_p[i] = d;
      end
      cyc++;
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clock);
    cmd_valid[0] = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_wins: busy=%b required 0", busy[0]); end
    cmd_valid[0] = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < NI; i++) begin
      n_cmp++; if (cmd_ready[i] !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready[%0d]: %b required 1", i, cmd_ready[i]); end
      n_cmp++; if (busy[i] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: %b required 0", i, busy[i]); end
      n_cmp++; if (done[i] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: %b required 0", i, done[i]); end
      n_cmp++; if (nack[i] !== 1'b0) begin n_fail++; $display("FAIL reset_nack[%0d]: %b required 0", i, nack[i]); end
      n_cmp++; if (scl_oe[i] !== 1'b0) begin n_fail++; $display("FAIL reset_scl_oe[%0d]: %b required 0", i, scl_oe[i]); end
      n_cmp++; if (sda_oe[i] !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe[%0d]: %b required 0", i, sda_oe[i]); end
    end
  endtask

  // Address NACK, nominal write, data-MSB NACK on the CLK_DIV=4 instance.
  task automatic test_write_cases();
    logic [6:0]  t_addr [3] = '{7'h4C, 7'h4C, 7'h1D};
    logic [7:0]  t_byte [3] = '{8'h30, 8'h30, 8'hC5};
    logic [15:0] t_data [3] = '{16'hABCD, 16'hABCD, 16'h1234};
    int          t_k    [3] = '{0, 4, 2};
    int          t_lat  [3] = '{176, 608, 464};
    logic        t_nack [3] = '{1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 3; c++) begin
      int n;
      nack_at[0] = t_k[c];
      push_expected(t_addr[c], t_byte[c], t_data[c], t_k[c]);
      @(negedge clock);
      cmd_addr = t_addr[c]; cmd_byte = t_byte[c]; cmd_data = t_data[c]; cmd_valid[0] = 1'b1;
      n_cmp++; if (cmd_ready[0] !== 1'b1) begin n_fail++; $display("FAIL case%0d_accept: cmd_ready=%b required 1", c, cmd_ready[0]); end
      @(negedge clock);
      cmd_valid[0] = 1'b0; cmd_addr = ~t_addr[c]; cmd_byte = ~t_byte[c]; cmd_data = ~t_data[c];
      n_cmp++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL case%0d_busy: %b required 1", c, busy[0]); end
      n_cmp++; if (cmd_ready[0] !== 1'b0) begin n_fail++; $display("FAIL case%0d_ready_drop: %b required 0", c, cmd_ready[0]); end
      n_cmp++; if (nack[0] !== 1'b0) begin n_fail++; $display("FAIL case%0d_nack_clear: %b required 0", c, nack[0]); end
      n = 1;
      while (done[0] !== 1'b1 && n < LIM) begin @(negedge clock); n++; end
      n_cmp++; if (n != t_lat[c]) begin n_fail++; $display("FAIL case%0d_latency: %0d required %0d", c, n, t_lat[c]); end
      n_cmp++; if (nack[0] !== t_nack[c]) begin n_fail++; $display("FAIL case%0d_nack: %b required %b", c, nack[0], t_nack[c]); end
      @(negedge clock);
      n_cmp++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL case%0d_idle: busy=%b required 0", c, busy[0]); end
      n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL case%0d_events_left: %0d required 0", c, exp_q.size()); end
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int n, gaps;
    nack_at[0] = 4;
    push_expected(7'h60, 8'h01, 16'h8001, 4);
    push_expected(7'h11, 8'h5A, 16'h0F3C, 4);
    @(negedge clock);
    cmd_addr = 7'h60; cmd_byte = 8'h01; cmd_data = 16'h8001; cmd_valid[0] = 1'b1;
    n_cmp++; if (cmd_ready[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_accept1: cmd_ready=%b required 1", cmd_ready[0]); end
    @(negedge clock);
    cmd_addr = 7'h11; cmd_byte = 8'h5A; cmd_data = 16'h0F3C;
    n = 1; gaps = 0;
    while (done[0] !== 1'b1 && n < LIM) begin
      @(negedge clock); n++;
      if (done[0] !== 1'b1 && busy[0] !== 1'b1) gaps++;
    end
    n_cmp++; if (n != 608) begin n_fail++; $display("FAIL b2b_latency1: %0d required 608", n); end
    n_cmp++; if (cmd_ready[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in_done: %b required 1", cmd_ready[0]); end
    @(negedge clock);
    cmd_valid[0] = 1'b0;
    n_cmp++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_accept2: busy=%b required 1", busy[0]); end
    n = 1;
    while (done[0] !== 1'b1 && n < LIM) begin
      @(negedge clock); n++;
      if (done[0] !== 1'b1 && busy[0] !== 1'b1) gaps++;
    end
    n_cmp++; if (n != 608) begin n_fail++; $display("FAIL b2b_latency2: %0d required 608", n); end
    n_cmp++; if (gaps != 0) begin n_fail++; $display("FAIL b2b_idle_gap: %0d cycles required 0", gaps); end
    @(negedge clock);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_events_left: %0d required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    int n, seen;
    nack_at[0] = 4;
    exp_q.push_back(EV_START);
    exp_q.push_back(EV_BYTE + 32'h44);
    @(negedge clock);
    cmd_addr = 7'h22; cmd_byte = 8'h77; cmd_data = 16'h5555; cmd_valid[0] = 1'b1;
    @(negedge clock);
    cmd_valid[0] = 1'b0;
    repeat (199) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_cmp++; if (scl_oe[0] !== 1'b0) begin n_fail++; $display("FAIL mid_reset_scl_oe: %b required 0", scl_oe[0]); end
    n_cmp++; if (sda_oe[0] !== 1'b0) begin n_fail++; $display("FAIL mid_reset_sda_oe: %b required 0", sda_oe[0]); end
    n_cmp++; if (cmd_ready[0] !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: %b required 1", cmd_ready[0]); end
    n_cmp++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: %b required 0", busy[0]); end
    reset = 1'b0;
    seen = 0;
    for (int t = 0; t < 700; t++) begin
      @(negedge clock);
      if (done[0] === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL mid_reset_done: %0d pulses required 0", seen); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_reset_events_left: %0d required 0", exp_q.size()); end
    exp_q.delete();
    push_expected(7'h3A, 8'h9C, 16'hE00F, 4);
    @(negedge clock);
    cmd_addr = 7'h3A; cmd_byte = 8'h9C; cmd_data = 16'hE00F; cmd_valid[0] = 1'b1;
    @(negedge clock);
    cmd_valid[0] = 1'b0;
    n = 1;
    while (done[0] !== 1'b1 && n < LIM) begin @(negedge clock); n++; end
    n_cmp++; if (n != 608) begin n_fail++; $display("FAIL after_reset_latency: %0d required 608", n); end
    n_cmp++; if (nack[0] !== 1'b0) begin n_fail++; $display("FAIL after_reset_nack: %b required 0", nack[0]); end
    @(negedge clock);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL after_reset_events_left: %0d required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_protocol_div();
    for (int i = 1; i < NI; i++) begin
      int n;
      nack_at[i] = 4;
      push_expected(7'h55, 8'hA3, 16'h6C91, 4);
      @(negedge clock);
      cmd_addr = 7'h55; cmd_byte = 8'hA3; cmd_data = 16'h6C91; cmd_valid[i] = 1'b1;
      n_cmp++; if (cmd_ready[i] !== 1'b1) begin n_fail++; $display("FAIL div%0d_accept: cmd_ready=%b required 1", div_of(i), cmd_ready[i]); end
      @(negedge clock);
      cmd_valid[i] = 1'b0;
      n = 1;
      while (done[i] !== 1'b1 && n < LIM) begin @(negedge clock); n++; end
      n_cmp++; if (n != 152 * div_of(i)) begin n_fail++; $display("FAIL div%0d_latency: %0d required %0d", div_of(i), n, 152 * div_of(i)); end
      n_cmp++; if (nack[i] !== 1'b0) begin n_fail++; $display("FAIL div%0d_nack: %b required 0", div_of(i), nack[i]); end
      @(negedge clock);
      n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL div%0d_events_left: %0d required 0", div_of(i), exp_q.size()); end
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_write_cases();
    test_back_to_back();
    test_mid_reset();
    test_protocol_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
